// File: rtl/fmap_stream_sequencer.sv
// fmap_stream_sequencer
//   Streams feature-map pixels from the per-channel input FIFO bank into the
//   first conv stage. Each beat pops every channel FIFO in lockstep and tags
//   the beat with row/frame/flush markers. Once NUM_IMG real frames have been
//   sent, zero-valued flush frames can follow to drain downstream line buffers.
//
//   Optional feature macro: FMAP_SEQ_FLUSH_FRAMES_EN
//     defined   -> FLUSH_IMG zero frames follow the real frames (out_flush=1)
//     undefined -> the run ends after the real frames, out_flush tied 0
//
// Ports
//   clk, resetn      clock, asynchronous active-low reset
//   start            run request (only honoured in IDLE)
//   fifo_empty       OR of all channel FIFO empties (show-ahead FIFOs)
//   fifo_data        channel pixels, channel 0 in the LSBs
//   fifo_rdreq       pop all channel FIFOs (combinational)
//   out_data         registered beat data
//   out_valid        beat valid
//   out_ready        downstream accept
//   out_eol/out_eof  beat is last pixel of a row / of a frame
//   out_flush        beat belongs to a flush frame
//   out_img          frame index of the beat
//   busy             sequencer is not idle
//   done             one-cycle pulse when the final beat leaves (combinational)
module fmap_stream_sequencer #(
  parameter int unsigned DWIDTH    = 32,
  parameter int unsigned NUM_CH    = 8,
  parameter int unsigned WIDTH     = 56,
  parameter int unsigned HEIGHT    = 56,
  parameter int unsigned NUM_IMG   = 1,
  parameter int unsigned FLUSH_IMG = 5
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     start,
  input  logic                     fifo_empty,
  input  logic [NUM_CH*DWIDTH-1:0] fifo_data,
  output logic                     fifo_rdreq,
  output logic [NUM_CH*DWIDTH-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_eol,
  output logic                     out_eof,
  output logic                     out_flush,
  output logic [9:0]               out_img,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned BUS_W = NUM_CH * DWIDTH;
  localparam int unsigned COL_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int unsigned ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int unsigned IMG_W = 10;
`ifdef FMAP_SEQ_FLUSH_FRAMES_EN
  localparam int unsigned RUN_IMG = NUM_IMG + FLUSH_IMG;
`else
  localparam int unsigned RUN_IMG = NUM_IMG;
`endif

  localparam logic [COL_W-1:0] COL_LAST      = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST      = ROW_W'(HEIGHT - 1);
  localparam logic [IMG_W-1:0] IMG_LAST_REAL = IMG_W'(NUM_IMG - 1);
  localparam logic [IMG_W-1:0] IMG_LAST_RUN  = IMG_W'(RUN_IMG - 1);

  // Reject frame counts that cannot be represented on out_img.
  if ((NUM_IMG < 1) || (NUM_IMG + FLUSH_IMG > 1023)) begin : g_cfg_err
    $error("fmap_stream_sequencer: frame counts out of range");
  end

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DRAIN} state_t;

  state_t           state, state_nxt;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [IMG_W-1:0] img;

  logic can_load;
  logic load_data;
  logic load_zero;
  logic load;
  logic clr_cnt;
  logic beat_eol;
  logic beat_eof;

  assign can_load = !out_valid || out_ready;
  assign beat_eol = (col == COL_LAST);
  assign beat_eof = beat_eol && (row == ROW_LAST);
  assign load     = load_data || load_zero;
  assign busy     = (state != IDLE);

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state, FIFO pop and load strobes.
  always_comb begin
    state_nxt  = state;
    fifo_rdreq = 1'b0;
    load_data  = 1'b0;
    load_zero  = 1'b0;
    clr_cnt    = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = STREAM;
          clr_cnt   = 1'b1;
        end
      end
      STREAM: begin
        fifo_rdreq = !fifo_empty && can_load;
        load_data  = !fifo_empty && can_load;
        if (load_data && beat_eof && (img == IMG_LAST_REAL)) begin
`ifdef FMAP_SEQ_FLUSH_FRAMES_EN
          state_nxt = FLUSH;
`else
          state_nxt = DRAIN;
`endif
        end
      end
`ifdef FMAP_SEQ_FLUSH_FRAMES_EN
      FLUSH: begin
        load_zero = can_load;
        if (load_zero && beat_eof && (img == IMG_LAST_RUN)) state_nxt = DRAIN;
      end
`endif
      DRAIN: begin
        // Final beat already gone or leaving this cycle.
        if (!out_valid || out_ready) begin
          state_nxt = IDLE;
          done      = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pixel position counters; advance with every loaded beat.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      col <= '0;
      row <= '0;
      img <= '0;
    end else if (clr_cnt) begin
      col <= '0;
      row <= '0;
      img <= '0;
    end else if (load) begin
      if (beat_eol) begin
        col <= '0;
        if (beat_eof) begin
          row <= '0;
          img <= img + IMG_W'(1);
        end else begin
          row <= row + ROW_W'(1);
        end
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  // Output beat register; holds while stalled, a load replaces an accepted beat.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_eol   <= 1'b0;
      out_eof   <= 1'b0;
      out_img   <= '0;
    end else if (load) begin
      out_data  <= load_data ? fifo_data : BUS_W'(0);
      out_valid <= 1'b1;
      out_eol   <= beat_eol;
      out_eof   <= beat_eof;
      out_img   <= img;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef FMAP_SEQ_FLUSH_FRAMES_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)   out_flush <= 1'b0;
    else if (load) out_flush <= load_zero;
  end
`else
  assign out_flush = 1'b0;
`endif

endmodule

// File: tb/tb_fmap_stream_sequencer.sv
// Testbench for fmap_stream_sequencer: directed runs with randomized FIFO
// contents, backpressure and FIFO-empty patterns, checked against a
// beat-index based reference model.
module tb_fmap_stream_sequencer;

  localparam int unsigned DW    = 32;
  localparam int unsigned NC    = 2;
  localparam int unsigned BW    = DW * NC;
  localparam int unsigned W     = 4;
  localparam int unsigned H     = 3;
  localparam int unsigned NI    = 2;
  localparam int unsigned FI    = 2;
  localparam int unsigned FB    = W * H;
  localparam int unsigned REAL  = NI * FB;
`ifdef FMAP_SEQ_FLUSH_FRAMES_EN
  localparam int unsigned TOTAL = (NI + FI) * FB;
`else
  localparam int unsigned TOTAL = NI * FB;
`endif
  localparam int unsigned SRC_N = REAL + 16;

  logic          clk;
  logic          resetn;
  logic          start;
  logic          fifo_empty;
  logic [BW-1:0] fifo_data;
  logic          fifo_rdreq;
  logic [BW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_eol;
  logic          out_eof;
  logic          out_flush;
  logic [9:0]    out_img;
  logic          busy;
  logic          done;

  fmap_stream_sequencer #(
    .DWIDTH(DW), .NUM_CH(NC), .WIDTH(W), .HEIGHT(H), .NUM_IMG(NI), .FLUSH_IMG(FI)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_rdreq(fifo_rdreq), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_eol(out_eol),
    .out_eof(out_eof), .out_flush(out_flush), .out_img(out_img),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [BW-1:0] src [SRC_N];
  int head;
  int tests;
  int fails;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic refill();
    for (int i = 0; i < int'(SRC_N); i++) src[i] = {$urandom, $urandom};
    head = 0;
  endtask

  // mode 0: full rate, 1: 3-cycle stall at beat index 5,
  // 2: fifo_empty toggles, 3: random ready/empty/start.
  // rst_at >= 0 asserts reset once that many beats have been accepted.
  task automatic run(input int mode, input int rst_at);
    int base, acc_cnt, pops, dones, done_step, stall_n;
    logic held, rd, acc, last;
    logic [BW-1:0] h_data;
    logic [9:0] h_img;
    logic h_eol, h_eof, h_flush;
    logic [BW-1:0] e_data;
    bit aborted;
    base = head; acc_cnt = 0; pops = 0; dones = 0; done_step = -1;
    stall_n = 0; held = 1'b0; aborted = 0;
    h_data = '0; h_img = '0; h_eol = 1'b0; h_eof = 1'b0; h_flush = 1'b0;
    for (int s = 0; s < 3000; s++) begin
      start = (s == 0) ? 1'b1 : ((mode == 3) ? 1'($urandom_range(0, 1)) : 1'b0);
      out_ready = 1'b1;
      if (mode == 1 && out_valid && acc_cnt == 5 && stall_n < 3) begin
        out_ready = 1'b0;
        stall_n++;
      end
      if (mode == 3) out_ready = ($urandom_range(0, 3) != 0);
      case (mode)
        2:       fifo_empty = s[0];
        3:       fifo_empty = ($urandom_range(0, 2) == 0);
        default: fifo_empty = 1'b0;
      endcase
      if (head >= int'(SRC_N)) fifo_empty = 1'b1;
      fifo_data = (head < int'(SRC_N)) ? src[head] : '0;
      #1;
      if (held) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_data", out_data, h_data);
        chk("hold_img", out_img, h_img);
        chk("hold_marks", {out_eol, out_eof, out_flush}, {h_eol, h_eof, h_flush});
      end
      rd  = fifo_rdreq;
      acc = out_valid && out_ready;
      if (rd) chk("rdreq_empty", fifo_empty, 1'b0);
      if (out_valid && !out_ready) chk("rdreq_stall", rd, 1'b0);
      last = acc && (acc_cnt == int'(TOTAL) - 1);
      chk("done", done, last);
      chk("busy", busy, s > 0);
      if (acc) begin
        e_data = (acc_cnt < int'(REAL)) ? src[base + acc_cnt] : '0;
        chk("data", out_data, e_data);
        chk("eol", out_eol, (acc_cnt % W) == W - 1);
        chk("eof", out_eof, (acc_cnt % FB) == FB - 1);
        chk("flush", out_flush, acc_cnt >= int'(REAL));
        chk("img", out_img, acc_cnt / FB);
        acc_cnt++;
      end
      if (done) begin
        dones++;
        if (done_step < 0) done_step = s;
      end
      held = out_valid && !out_ready;
      h_data = out_data; h_img = out_img;
      h_eol = out_eol; h_eof = out_eof; h_flush = out_flush;
      if (rst_at >= 0 && acc_cnt == rst_at) begin
        resetn = 1'b0;
        #1;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_data", out_data, '0);
        chk("rst_marks", {out_eol, out_eof, out_flush, busy, done, fifo_rdreq}, '0);
        chk("rst_img", out_img, '0);
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        aborted = 1;
        break;
      end
      @(posedge clk);
      if (rd) begin
        head++;
        pops++;
      end
      @(negedge clk);
      if (dones > 0) break;
    end
    start = 1'b0;
    if (!aborted) begin
      chk("done_once", dones, 1);
      chk("pops", pops, REAL);
      chk("beats", acc_cnt, TOTAL);
      chk("busy_after", busy, 1'b0);
      if (mode == 0) chk("latency", done_step, TOTAL + 1);
    end
  endtask

  initial begin
    tests = 0; fails = 0;
    resetn = 1'b0; start = 1'b0; fifo_empty = 1'b1; out_ready = 1'b1;
    fifo_data = '0;
    refill();
    repeat (2) @(negedge clk);
    chk("reset_valid", out_valid, 1'b0);
    chk("reset_data", out_data, '0);
    chk("reset_marks", {out_eol, out_eof, out_flush}, '0);
    chk("reset_img", out_img, '0);
    chk("reset_ctl", {busy, done, fifo_rdreq}, '0);
    resetn = 1'b1;
    @(negedge clk);

    refill(); run(0, -1);
    refill(); run(1, -1);
    refill(); run(2, -1);
    refill(); run(3, -1);
    refill(); run(0, 7);
    run(0, -1);
    refill(); run(3, -1);
    refill(); run(3, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fmap_stream_sequencer.md
# fmap_stream_sequencer

Sequences feature-map streaming from the per-channel input FIFOs into the convolution datapath. Each beat pops one pixel from all NUM_CH channel FIFOs in lockstep and tags it with row, frame and flush markers. After NUM_IMG real frames it optionally injects zero-valued flush frames to drain the line-buffer and window pipeline downstream. It sits between the input FIFO bank and the first conv stage, and is started per layer by the top-level control.

## Interface
- DWIDTH, 32, bits per channel pixel
- NUM_CH, 8, channels streamed in lockstep
- WIDTH, 56, pixels per row
- HEIGHT, 56, rows per frame
- NUM_IMG, 1, real frames per run (≥1)
- FLUSH_IMG, 5, zero flush frames per run (≥1 when flush compiled in); NUM_IMG+FLUSH_IMG ≤ 1023

- clk  in  1  single clock, rising edge
- resetn  in  1  reset, asynchronous, active-low
- start  in  1  run request, sampled only in IDLE
- fifo_empty  in  1  OR of all channel FIFO empties (show-ahead FIFOs)
- fifo_data  in  NUM_CH*DWIDTH  channel pixels, channel 0 in LSBs
- fifo_rdreq  out  1  pop all channel FIFOs (combinational)
- out_data  out  NUM_CH*DWIDTH  registered beat data
- out_valid  out  1  beat valid
- out_ready  in  1  downstream accept
- out_eol  out  1  beat is last pixel of a row
- out_eof  out  1  beat is last pixel of a frame
- out_flush  out  1  beat belongs to a flush frame
- out_img  out  10  frame index of the beat (0-based; flush frames continue numbering)
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at end of run

## Operation
- States: IDLE, STREAM, FLUSH, DRAIN.
- IDLE: start=1 → STREAM, and col/row/img counters cleared. start outside IDLE is ignored.
- can_load = !out_valid || out_ready.
- STREAM:
  - fifo_rdreq = !fifo_empty && can_load.
  - On rdreq, the output register loads fifo_data, counters advance, and out_flush=0.
- FLUSH:
  - fifo_rdreq=0.
  - On can_load, the output register loads all-zero data with out_flush=1, and counters advance.
- Output register with no new load:
  - out_ready=1 → out_valid clears.
  - Otherwise out_data and all markers are held stable.
- Counters:
  - col 0..WIDTH-1 wraps and increments row.
  - row 0..HEIGHT-1 wraps and increments img.
  - Widths are $clog2 of the bound (min 1).
- Markers are registered with the beat:
  - out_eol when col==WIDTH-1.
  - out_eof when col==WIDTH-1 && row==HEIGHT-1.
  - out_img = img.
- Last real beat loaded (eof && img==NUM_IMG-1) → FLUSH.
- Last flush beat loaded (eof && img==NUM_IMG+FLUSH_IMG-1) → DRAIN.
- DRAIN: no loads. When out_valid==0, or out_valid && out_ready → IDLE with done=1 for that cycle.
- fifo_empty in FLUSH/DRAIN is ignored. FIFO data beyond the frame count is never popped.

## Timing
- Reset values:
  - State IDLE, all counters 0.
  - out_data 0, out_valid 0, out_eol/out_eof/out_flush 0, out_img 0.
  - done 0, busy 0, fifo_rdreq 0.
- Reset asserted mid-run: all of the above take effect immediately (async), and the partial frame is discarded. No resume; a new start is required.
- start sampled at edge N → STREAM after N. First possible rdreq in cycle N+1. out_valid high after edge N+1.
- Throughput is 1 beat/cycle with out_ready=1 and fifo_empty=0. The output register is back-to-back with no bubble.
- out_valid is never dropped without acceptance. out_data/markers do not change while out_valid && !out_ready.
- Simultaneous accept and load: the new beat replaces the old in the same edge.
- done is asserted in the cycle the final beat is accepted (or the first DRAIN cycle if already accepted). busy falls at the next edge.

## Configuration
- Macro FMAP_SEQ_FLUSH_FRAMES_EN.
- Defined: FLUSH state and zero frames are generated as above.
- Undefined:
  - FLUSH state is removed; last real beat → DRAIN.
  - out_flush is tied 0 and FLUSH_IMG is ignored.
  - out_img max is NUM_IMG-1.

## Test plan
- WIDTH=4, HEIGHT=3, NUM_IMG=2, FLUSH_IMG=2, fifo_empty=0, out_ready=1, start pulse, FIFO data = beat count:
  - 24 data beats 0..23, then 24 zero beats with out_flush=1.
  - out_eol on every 4th beat; out_eof on beats 12/24/36/48; out_img 0,1,2,3.
  - done exactly once, on beat 48's accept cycle.
- Same setup, out_ready low for 3 cycles at beat 6:
  - out_data=5 held stable, fifo_rdreq=0 throughout.
  - Resumes with 6; no beat dropped or duplicated.
- fifo_empty toggling every cycle in STREAM:
  - rdreq only when empty=0; exactly 24 pops.
  - Flush frames are emitted at full rate despite empty=1.
- resetn pulsed low at beat 7:
  - All outputs 0 immediately, busy=0.
  - A new start restarts at out_img=0, col=0, with the first beat equal to the FIFO head.
- start re-pulsed while busy: ignored, single done.
- Macro undefined: 24 beats, then done, out_flush never 1.
